// File: rtl/fma_rsh_sticky_pipe.sv
// -----------------------------------------------------------------------------
// fma_rsh_sticky_pipe
//
// This is a two-stage pipelined right shifter for FMA/FADD alignment. It sits
// between the exponent-difference logic and the aligned-addend adder. For each
// transaction it produces:
//    - the operand shifted right with zero fill,
//    - the guard bit (the last bit shifted out),
//    - the sticky bit (OR of every lost bit below the guard),
//    - the full lost-bit mask.
//
// Both sides use a valid/ready handshake. Shift amounts of DATA_W and above
// are handled, and flush_i drops all in-flight work.
//
// Ports
//    clk          clock
//    rst_n        asynchronous active-low reset
//    flush_i      synchronous clear of every in-flight transaction
//    in_valid_i   input transaction valid
//    in_ready_o   block can accept an input this cycle
//    data_i       operand to shift (DATA_W bits)
//    rsh_num_i    right-shift amount (SHIFT_W bits; values >= DATA_W allowed)
//    out_valid_o  result valid
//    out_ready_i  downstream accepts the result
//    data_o       data_i >> min(rsh_num_i, DATA_W), zero filled
//    guard_o      data_i[rsh_num_i-1]; 0 for a shift of 0 or beyond DATA_W
//    sticky_o     OR of data_i bits below the guard; |data_i beyond DATA_W
//    lost_mask_o  bit i set when i < rsh_num_i
// -----------------------------------------------------------------------------
module fma_rsh_sticky_pipe #(
   parameter int DATA_W  = 64,
   parameter int SHIFT_W = $clog2(DATA_W) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHIFT_W-1:0] rsh_num_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [DATA_W-1:0]  data_o,
   output logic               guard_o,
   output logic               sticky_o,
   output logic [DATA_W-1:0]  lost_mask_o
);

   localparam logic [SHIFT_W-1:0] DW_S = SHIFT_W'(DATA_W);
   localparam logic [DATA_W-1:0]  ONES = {DATA_W{1'b1}};

   // Saturate the shift amount at DATA_W; anything larger loses every bit.
   function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] n);
      return (n > DW_S) ? DW_S : n;
   endfunction

   // Lost-bit mask: ones below the shift amount.
   // A shift of DATA_W pushes every one out of ONES, so the mask becomes all ones.
   function automatic logic [DATA_W-1:0] lost_mask(input logic [SHIFT_W-1:0] n);
      return ~(ONES << n);
   endfunction

   // The guard is the top lost bit. It is the only bit where the mask differs
   // from the mask shifted down by one.
   // A shift past DATA_W has no guard position, so the guard is 0.
   function automatic logic guard_bit(input logic [DATA_W-1:0] d,
                                      input logic [DATA_W-1:0] m,
                                      input logic              over);
      logic [DATA_W-1:0] sel;
      sel = over ? '0 : (m ^ (m >> 1));
      return |(d & sel);
   endfunction

   // The sticky bit is the OR of the lost bits below the guard.
   // A shift past DATA_W folds every bit, including the MSB, into sticky.
   function automatic logic sticky_bit(input logic [DATA_W-1:0] d,
                                       input logic [DATA_W-1:0] m,
                                       input logic              over);
      logic [DATA_W-1:0] sel;
      sel = over ? ONES : (m >> 1);
      return |(d & sel);
   endfunction

   logic               vld_p1;
   logic [DATA_W-1:0]  data_p1;
   logic [SHIFT_W-1:0] shamt_p1;
   logic [DATA_W-1:0]  mask_p1;
   logic               over_p1;

   logic               vld_p2;
   logic [DATA_W-1:0]  data_p2;
   logic               guard_p2;
   logic               sticky_p2;
   logic [DATA_W-1:0]  mask_p2;

   logic               load_p1;
   logic               load_p2;
   logic               accept;

   // A stage may load when it is empty or when its content moves on this cycle.
   assign load_p2    = !vld_p2 || out_ready_i;
   assign load_p1    = !vld_p1 || load_p2;
   assign in_ready_o = load_p1;
   assign accept     = in_valid_i && in_ready_o;

   // Valid bits. Flush wins over any load. A stage empties when it hands its
   // content on and nothing new arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else if (flush_i) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (load_p1) vld_p1 <= accept;
         if (load_p2) vld_p2 <= vld_p1;
      end
   end

   // ---- stage 1: capture operand, clamped shift and lost mask ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p1  <= '0;
         shamt_p1 <= '0;
         mask_p1  <= '0;
         over_p1  <= 1'b0;
      end else if (accept) begin
         data_p1  <= data_i;
         shamt_p1 <= clamp_shift(rsh_num_i);
         mask_p1  <= lost_mask(clamp_shift(rsh_num_i));
         over_p1  <= (rsh_num_i > DW_S);
      end
   end

   // ---- stage 2: shift and extract guard / sticky ----
   // Payload only moves when stage 1 holds a real transaction, so these
   // registers never pick up undriven input data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p2   <= '0;
         guard_p2  <= 1'b0;
         sticky_p2 <= 1'b0;
         mask_p2   <= '0;
      end else if (load_p2 && vld_p1) begin
         data_p2   <= data_p1 >> shamt_p1;
         guard_p2  <= guard_bit(data_p1, mask_p1, over_p1);
         sticky_p2 <= sticky_bit(data_p1, mask_p1, over_p1);
         mask_p2   <= mask_p1;
      end
   end

   // ---- outputs: straight from stage 2 registers ----
   assign out_valid_o = vld_p2;
   assign data_o      = data_p2;
   assign guard_o     = guard_p2;
   assign sticky_o    = sticky_p2;
   assign lost_mask_o = mask_p2;

endmodule
